// File: rtl/instruction_prefetch_buffer.sv
// Instruction prefetch queue: fetches sequential words into a DEPTH-entry {pc, instr} FIFO, redirected by taken branches.
// Optional macro BRANCH_BYPASS_EN: issue the branch target fetch in the branch cycle instead of a one-cycle bubble.
module instruction_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isbranchtaken,
  input  logic [31:0] branchpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc_current
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {FETCH, HOLD, REDIRECT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic          push, pop;
  logic [PW-1:0] wr_idx;
  logic [31:0]   push_pc;

  // Outputs are gated by reset so the request drops the moment reset is asserted.
  always_comb begin
    imem_req  = reset && (state_q == FETCH);
    imem_addr = fetch_pc_q;
`ifdef BRANCH_BYPASS_EN
    if (reset && isbranchtaken) begin
      imem_req  = 1'b1;
      imem_addr = branchpc;
    end
`endif
    if_valid    = (count_q != '0);
    instruction = if_valid ? ins_mem[head_q] : 32'd0;
    pc_current  = if_valid ? pc_mem[head_q]  : 32'd0;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    push       = 1'b0;
    pop        = 1'b0;
    wr_idx     = tail_q;
    push_pc    = fetch_pc_q;
    if (isbranchtaken) begin
      // A branch flushes everything, including any response arriving this cycle.
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = branchpc;
`ifdef BRANCH_BYPASS_EN
      state_d = FETCH;
      wr_idx  = '0;
      push_pc = branchpc;
      if (imem_ack) begin
        push       = 1'b1;
        tail_d     = PW'(1);
        count_d    = CW'(1);
        fetch_pc_d = branchpc + 32'd4;
      end
`else
      state_d = REDIRECT;
`endif
    end else begin
      pop  = if_valid && if_ready;
      push = (state_q == FETCH) && imem_ack;
      if (push) begin
        tail_d     = tail_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      unique case (state_q)
        FETCH:    if (count_d == FULL) state_d = HOLD;
        HOLD:     if (count_d != FULL) state_d = FETCH;
        REDIRECT: state_d = FETCH;
        default:  state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Storage carries no reset; stale entries are never visible because count gates the head.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_idx]  <= push_pc;
      ins_mem[wr_idx] <= imem_rdata;
    end
  end

endmodule

// File: doc/instruction_prefetch_buffer.md
INSTRUCTION_PREFETCH_BUFFER -- requirements
Module: instruction_prefetch_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queue entries (power of 2, at least 2).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port isbranchtaken, input, 1 bit: redirect request from execute.
REQ-006 The block SHALL have port branchpc, input, 32 bits: redirect target, valid when isbranchtaken=1.
REQ-007 The block SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-008 The block SHALL have port imem_addr, output, 32 bits: word-aligned fetch address.
REQ-009 The block SHALL have port imem_ack, input, 1 bit: read complete; imem_rdata valid this cycle.
REQ-010 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-011 The block SHALL have port if_valid, output, 1 bit: queue head holds an instruction.
REQ-012 The block SHALL have port if_ready, input, 1 bit: downstream fetch/operand-fetch register accepts the head.
REQ-013 The block SHALL have port instruction, output, 32 bits: head instruction word.
REQ-014 The block SHALL have port pc_current, output, 32 bits: PC of the head instruction.

Function
REQ-015 The FIFO SHALL store {pc, instruction} pairs, with head/tail pointers wrapping modulo DEPTH and a count register sized 0..DEPTH.
REQ-016 The FSM SHALL have exactly three states: FETCH (imem_req=1), HOLD (queue full, imem_req=0) and REDIRECT (one-cycle bubble, imem_req=0).
REQ-017 In FETCH, imem_req and imem_addr=fetch_pc SHALL stay stable until imem_ack=1; on ack, the pair {fetch_pc, imem_rdata} SHALL be pushed and fetch_pc SHALL advance by 4, wrapping at 2^32.
REQ-018 imem_ack SHALL be ignored whenever imem_req=0.
REQ-019 FETCH SHALL go to HOLD when count after the push equals DEPTH; HOLD SHALL return to FETCH in the cycle after a pop makes count less than DEPTH.
REQ-020 A pop SHALL occur when if_valid=1 and if_ready=1; a push and pop in the same cycle SHALL leave count unchanged, including at count=DEPTH-1.
REQ-021 if_valid SHALL be 1 exactly when count>0; instruction and pc_current SHALL be driven combinationally from the head entry, and SHALL be 0 when count=0.
REQ-022 isbranchtaken=1 SHALL take priority over push, pop and ack in the same cycle: the FIFO is emptied (count=0, pointers=0), any same-cycle ack data is discarded, fetch_pc is set to branchpc, and the next state is REDIRECT, from any state.
REQ-023 REDIRECT SHALL go to FETCH unconditionally after one cycle; a new isbranchtaken during REDIRECT SHALL reload fetch_pc and remain in REDIRECT.
REQ-024 Latency SHALL be: ack at cycle N gives if_valid=1 at cycle N+1 when the queue was empty.

Reset
REQ-025 While reset=0, outputs SHALL be: imem_req=0, imem_addr=RESET_PC, if_valid=0, instruction=0, pc_current=0; fetch_pc SHALL be RESET_PC, count and pointers 0, and the state FETCH.
REQ-026 Reset asserted mid-request SHALL abandon the request immediately; the first rising edge after release SHALL see imem_req=1 at RESET_PC.

Configuration
REQ-027 When macro BRANCH_BYPASS_EN is defined, REDIRECT SHALL be skipped: in the isbranchtaken cycle, imem_req SHALL be 1 with imem_addr=branchpc combinationally, and an ack in that same cycle SHALL be pushed as {branchpc, imem_rdata}, with the next fetch_pc at branchpc+4.
REQ-028 When BRANCH_BYPASS_EN is undefined, the REDIRECT behaviour of REQ-022 and REQ-023 SHALL apply, giving one bubble cycle.

Verification
REQ-029 Release reset, imem_ack=1 every cycle, if_ready=1 -> addresses 0,4,8,...; pc_current follows one cycle later; if_valid stays 1 from cycle 2.
REQ-030 if_ready=0 with continuous ack, DEPTH=4 -> exactly 4 pushes (PC 0..C), imem_req=0 in HOLD; single if_ready pulse -> pop PC 0, one more fetch at 0x10.
REQ-031 Queue at 3 entries, push and pop in the same cycle -> count stays 3, no entry lost, order preserved.
REQ-032 isbranchtaken=1, branchpc=0x100, with ack in the same cycle -> ack data dropped, if_valid=0 next cycle, imem_req=0 for one cycle (bypass off), then address 0x100.
REQ-033 With BRANCH_BYPASS_EN, same stimulus -> imem_addr=0x100 in the branch cycle; next cycle if_valid=1 with pc_current=0x100.
REQ-034 Assert reset while imem_req=1 at 0x20 -> outputs immediately at reset values; after release, first address is RESET_PC.
